// File: rtl/acc_exec_unit.sv
// Accumulator execution unit: one instruction per valid/ready handshake, ACC + N/Z/C
// flags, multi-cycle logical shifts at STEP bits per cycle, branch and write strobes.
module acc_exec_unit #(
    parameter int unsigned W    = 8,
    parameter int unsigned STEP = 1
) (
    input  logic         CLK,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] operand,
    output logic [W-1:0] acc,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         out_valid,
    output logic         branch_taken,
    output logic         wr_reg,
    output logic         wr_mem
);

    localparam int unsigned CW = $clog2(W) + 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_STR = 4'h2;
    localparam logic [3:0] OP_LDR = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MLD = 4'h6;
    localparam logic [3:0] OP_MST = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_BRN = 4'hC;
    localparam logic [3:0] OP_BRZ = 4'hD;
    localparam logic [3:0] OP_NOT = 4'hE;
    localparam logic [3:0] OP_CLR = 4'hF;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t        r_state, w_state_nx;
    logic [W-1:0]  r_acc, w_acc_nx;
    logic          r_n, r_z, r_c;
    logic          w_n_nx, w_z_nx, w_c_nx;
    logic          r_out_valid, w_out_valid_nx;
    logic          r_branch, w_branch_nx;
    logic          r_wr_reg, w_wr_reg_nx;
    logic          r_wr_mem, w_wr_mem_nx;
    logic          r_in_ready;
    logic [CW-1:0] r_rem, w_rem_nx;
    logic          r_shl, w_shl_nx;

    logic          w_accept;
    logic          w_nz_upd;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_step;
    logic [W:0]    w_sum;
    logic [W-1:0]  w_shift_res;
    logic          w_last_out;

    assign w_accept    = in_valid & r_in_ready;
    assign w_cnt       = operand[CW-1:0];
    assign w_step      = (r_rem > CW'(STEP)) ? CW'(STEP) : r_rem;
    assign w_sum       = {1'b0, r_acc} + {1'b0, operand};
    assign w_shift_res = r_shl ? (r_acc << w_step) : (r_acc >> w_step);

    // Bit that falls off the end during this shift cycle (w_step >= 1 while shifting).
    assign w_last_out = r_shl ? |(r_acc & (W'(1) << (CW'(W) - w_step)))
                              : |(r_acc & (W'(1) << (w_step - CW'(1))));

    // Next-state, datapath and strobe decode.
    always_comb begin
        w_state_nx     = r_state;
        w_acc_nx       = r_acc;
        w_n_nx         = r_n;
        w_z_nx         = r_z;
        w_c_nx         = r_c;
        w_rem_nx       = r_rem;
        w_shl_nx       = r_shl;
        w_out_valid_nx = 1'b0;
        w_branch_nx    = 1'b0;
        w_wr_reg_nx    = 1'b0;
        w_wr_mem_nx    = 1'b0;
        w_nz_upd       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_out_valid_nx = 1'b1;
                    case (op)
                        OP_ADD: begin
                            {w_c_nx, w_acc_nx} = w_sum;
                            w_nz_upd = 1'b1;
                        end
                        OP_SUB: begin
                            w_acc_nx = r_acc - operand;
                            w_c_nx   = (r_acc >= operand);
                            w_nz_upd = 1'b1;
                        end
                        OP_STR: w_wr_reg_nx = 1'b1;
                        OP_MST: w_wr_mem_nx = 1'b1;
                        OP_LDR, OP_MLD, OP_LDI: begin
                            w_acc_nx = operand;
                            w_nz_upd = 1'b1;
                        end
                        OP_AND: begin
                            w_acc_nx = r_acc & operand;
                            w_nz_upd = 1'b1;
                        end
                        OP_XOR: begin
                            w_acc_nx = r_acc ^ operand;
                            w_nz_upd = 1'b1;
                        end
                        OP_NOT: begin
                            w_acc_nx = ~r_acc;
                            w_nz_upd = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            w_nz_upd = 1'b1;
                            if (w_cnt >= CW'(W)) begin
                                // Whole word shifted out in one cycle.
                                w_acc_nx = '0;
                                w_c_nx   = (w_cnt == CW'(W)) &
                                           ((op == OP_SHL) ? r_acc[0] : r_acc[W-1]);
                            end else if (w_cnt != '0) begin
                                w_nz_upd       = 1'b0;
                                w_out_valid_nx = 1'b0;
                                w_state_nx     = S_SHIFT;
                                w_rem_nx       = w_cnt;
                                w_shl_nx       = (op == OP_SHL);
                            end
                        end
                        OP_JMP: w_branch_nx = 1'b1;
                        OP_BRN: w_branch_nx = r_n;
                        OP_BRZ: w_branch_nx = r_z;
                        OP_CLR: begin
                            w_n_nx = 1'b0;
                            w_z_nx = 1'b0;
                            w_c_nx = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_SHIFT: begin
                w_acc_nx = w_shift_res;
                w_rem_nx = r_rem - w_step;
                if (r_rem == w_step) begin
                    w_state_nx     = S_IDLE;
                    w_out_valid_nx = 1'b1;
                    w_c_nx         = w_last_out;
                    w_nz_upd       = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (w_nz_upd) begin
            w_n_nx = w_acc_nx[W-1];
            w_z_nx = (w_acc_nx == '0);
        end
    end

    // State and architectural registers.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_valid <= 1'b0;
            r_branch    <= 1'b0;
            r_wr_reg    <= 1'b0;
            r_wr_mem    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_rem       <= '0;
            r_shl       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_acc       <= w_acc_nx;
            r_n         <= w_n_nx;
            r_z         <= w_z_nx;
            r_c         <= w_c_nx;
            r_out_valid <= w_out_valid_nx;
            r_branch    <= w_branch_nx;
            r_wr_reg    <= w_wr_reg_nx;
            r_wr_mem    <= w_wr_mem_nx;
            r_in_ready  <= (w_state_nx == S_IDLE);
            r_rem       <= w_rem_nx;
            r_shl       <= w_shl_nx;
        end
    end

    assign in_ready     = r_in_ready;
    assign acc          = r_acc;
    assign flag_n       = r_n;
    assign flag_z       = r_z;
    assign flag_c       = r_c;
    assign out_valid    = r_out_valid;
    assign branch_taken = r_branch;
    assign wr_reg       = r_wr_reg;
    assign wr_mem       = r_wr_mem;

endmodule

// File: tb/tb_acc_exec_unit.sv
// Bench for acc_exec_unit: STEP=1 and STEP=2 instances driven in lockstep, checked each
// cycle against an instruction-level model, plus hand-computed directed expectations.
module tb_acc_exec_unit;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_STR = 4'h2;
    localparam logic [3:0] OP_LDR = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MLD = 4'h6;
    localparam logic [3:0] OP_MST = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_BRN = 4'hC;
    localparam logic [3:0] OP_BRZ = 4'hD;
    localparam logic [3:0] OP_NOT = 4'hE;
    localparam logic [3:0] OP_CLR = 4'hF;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic [3:0] op;
    logic [7:0] operand;

    logic [1:0] d_rdy, d_ov, d_n, d_z, d_c, d_br, d_wr, d_wm;
    logic [7:0] d_acc [2];

    int n_checks = 0;
    int n_fail   = 0;

    acc_exec_unit #(.W(8), .STEP(1)) u_dut_s1 (
        .CLK(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d_rdy[0]),
        .op(op), .operand(operand), .acc(d_acc[0]), .flag_n(d_n[0]), .flag_z(d_z[0]),
        .flag_c(d_c[0]), .out_valid(d_ov[0]), .branch_taken(d_br[0]),
        .wr_reg(d_wr[0]), .wr_mem(d_wm[0])
    );

    acc_exec_unit #(.W(8), .STEP(2)) u_dut_s2 (
        .CLK(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d_rdy[1]),
        .op(op), .operand(operand), .acc(d_acc[1]), .flag_n(d_n[1]), .flag_z(d_z[1]),
        .flag_c(d_c[1]), .out_valid(d_ov[1]), .branch_taken(d_br[1]),
        .wr_reg(d_wr[1]), .wr_mem(d_wm[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d (STEP=%0d): got 0x%0h, expected 0x%0h at %0t",
                     name, lane, lane + 1, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    logic [7:0] m_acc [2];
    logic [7:0] m_orig [2];
    logic       m_n [2], m_z [2], m_c [2];
    logic       m_ov [2], m_br [2], m_wr [2], m_wm [2];
    logic       m_busy [2], m_dir [2];
    int         m_done [2], m_cnt [2];

    function automatic logic [7:0] shift_by(input logic [7:0] x, input int amt, input logic shl);
        if (amt >= 8) return 8'h00;
        return shl ? 8'(x << amt) : (x >> amt);
    endfunction

    // Last bit to leave the word when x is shifted by n (1..) positions.
    function automatic logic last_out(input logic [7:0] x, input int n, input logic shl);
        if (n > 8) return 1'b0;
        return shl ? x[8 - n] : x[n - 1];
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            m_acc[l] = 8'h00; m_orig[l] = 8'h00;
            m_n[l] = 1'b0; m_z[l] = 1'b0; m_c[l] = 1'b0;
            m_ov[l] = 1'b0; m_br[l] = 1'b0; m_wr[l] = 1'b0; m_wm[l] = 1'b0;
            m_busy[l] = 1'b0; m_dir[l] = 1'b0; m_done[l] = 0; m_cnt[l] = 0;
        end
    endtask

    // Advance lane l by one clock using the inputs presented this cycle.
    task automatic model_step(input int l);
        int  step;
        int  t;
        logic nz;
        step = l + 1;
        nz = 1'b0;
        m_ov[l] = 1'b0; m_br[l] = 1'b0; m_wr[l] = 1'b0; m_wm[l] = 1'b0;
        if (m_busy[l]) begin
            m_done[l]++;
            if (m_done[l] * step >= m_cnt[l]) begin
                m_busy[l] = 1'b0;
                m_acc[l]  = shift_by(m_orig[l], m_cnt[l], m_dir[l]);
                m_c[l]    = last_out(m_orig[l], m_cnt[l], m_dir[l]);
                m_ov[l]   = 1'b1;
                nz = 1'b1;
            end else begin
                m_acc[l] = shift_by(m_orig[l], m_done[l] * step, m_dir[l]);
            end
        end else if (in_valid) begin
            m_ov[l] = 1'b1;
            case (op)
                OP_ADD: begin
                    t = int'(m_acc[l]) + int'(operand);
                    m_c[l] = (t > 255); m_acc[l] = 8'(t); nz = 1'b1;
                end
                OP_SUB: begin
                    m_c[l] = (m_acc[l] >= operand);
                    m_acc[l] = 8'(int'(m_acc[l]) - int'(operand)); nz = 1'b1;
                end
                OP_STR: m_wr[l] = 1'b1;
                OP_MST: m_wm[l] = 1'b1;
                OP_LDR, OP_MLD, OP_LDI: begin m_acc[l] = operand; nz = 1'b1; end
                OP_AND: begin m_acc[l] = m_acc[l] & operand; nz = 1'b1; end
                OP_XOR: begin m_acc[l] = m_acc[l] ^ operand; nz = 1'b1; end
                OP_NOT: begin m_acc[l] = ~m_acc[l]; nz = 1'b1; end
                OP_JMP: m_br[l] = 1'b1;
                OP_BRN: m_br[l] = m_n[l];
                OP_BRZ: m_br[l] = m_z[l];
                OP_CLR: begin m_n[l] = 1'b0; m_z[l] = 1'b0; m_c[l] = 1'b0; end
                default: begin
                    t = int'(operand[3:0]);
                    if (t == 0) begin
                        nz = 1'b1;
                    end else if (t >= 8) begin
                        m_c[l] = last_out(m_acc[l], t, op == OP_SHL);
                        m_acc[l] = 8'h00; nz = 1'b1;
                    end else begin
                        m_busy[l] = 1'b1; m_done[l] = 0; m_cnt[l] = t;
                        m_orig[l] = m_acc[l]; m_dir[l] = (op == OP_SHL); m_ov[l] = 1'b0;
                    end
                end
            endcase
        end
        if (nz) begin
            m_n[l] = m_acc[l][7];
            m_z[l] = (m_acc[l] == 8'h00);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int l = 0; l < 2; l++) begin
                chk("m_in_ready", l, 32'(d_rdy[l]), 32'(!m_busy[l]));
                chk("m_out_valid", l, 32'(d_ov[l]), 32'(m_ov[l]));
                chk("m_acc", l, 32'(d_acc[l]), 32'(m_acc[l]));
                chk("m_flags_nzc", l, {29'd0, d_n[l], d_z[l], d_c[l]},
                    {29'd0, m_n[l], m_z[l], m_c[l]});
                if (m_ov[l]) begin
                    chk("m_strobes_br_wr_wm", l, {29'd0, d_br[l], d_wr[l], d_wm[l]},
                        {29'd0, m_br[l], m_wr[l], m_wm[l]});
                end
            end
            for (int l = 0; l < 2; l++) model_step(l);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!(d_rdy[0] && d_rdy[1]) && g < 64) begin
            tick();
            g++;
        end
        chk("idle_timeout", 0, 32'(g < 64), 32'd1);
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] v);
        wait_idle();
        in_valid = 1'b1; op = o; operand = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic lit_state(input string name, input logic [7:0] a, input logic n,
                             input logic z, input logic c);
        for (int l = 0; l < 2; l++) begin
            chk({name, "_acc"}, l, 32'(d_acc[l]), 32'(a));
            chk({name, "_nzc"}, l, {29'd0, d_n[l], d_z[l], d_c[l]}, {29'd0, n, z, c});
        end
    endtask

    logic [3:0] t_ops  [16];
    logic [7:0] t_vals [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; op = 4'h0; operand = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        lit_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 2; l++) begin
            chk("reset_rdy", l, 32'(d_rdy[l]), 32'd1);
            chk("reset_ov", l, 32'(d_ov[l]), 32'd0);
        end

        // Overflow into the sign bit.
        issue(OP_LDI, 8'h7F);
        issue(OP_ADD, 8'h01);
        chk("t1_ov", 0, 32'(d_ov[0]), 32'd1);
        lit_state("t1", 8'h80, 1'b1, 1'b0, 1'b0);

        // Borrow, then CLR leaves acc.
        issue(OP_LDI, 8'h05);
        issue(OP_SUB, 8'h06);
        lit_state("t2_sub", 8'hFF, 1'b1, 1'b0, 1'b0);
        issue(OP_CLR, 8'h00);
        lit_state("t2_clr", 8'hFF, 1'b0, 1'b0, 1'b0);
        issue(OP_STR, 8'h00);
        chk("t2_wr_reg", 0, {30'd0, d_wr[0], d_wm[0]}, 32'd2);
        issue(OP_MST, 8'h00);
        chk("t2_wr_mem", 1, {30'd0, d_wr[1], d_wm[1]}, 32'd1);

        // Carry out to zero, then branches.
        issue(OP_ADD, 8'h01);
        lit_state("t4_carry", 8'h00, 1'b0, 1'b1, 1'b1);
        issue(OP_BRZ, 8'h00);
        chk("t4_brz", 0, 32'(d_br[0]), 32'd1);
        issue(OP_BRN, 8'h00);
        chk("t4_brn", 1, 32'(d_br[1]), 32'd0);
        issue(OP_JMP, 8'h00);
        chk("t4_jmp", 0, 32'(d_br[0]), 32'd1);
        lit_state("t4_keep", 8'h00, 1'b0, 1'b1, 1'b1);

        // SHL 3 of 0x81: STEP=1 takes 3 cycles, STEP=2 takes 2.
        issue(OP_LDI, 8'h81);
        issue(OP_SHL, 8'h03);
        for (int i = 0; i < 4; i++) begin
            chk("t3_rdy_s1", 0, 32'(d_rdy[0]), 32'(i == 3));
            chk("t3_ov_s1", 0, 32'(d_ov[0]), 32'(i == 3));
            if (i < 3) begin
                chk("t3_rdy_s2", 1, 32'(d_rdy[1]), 32'(i == 2));
                chk("t3_ov_s2", 1, 32'(d_ov[1]), 32'(i == 2));
                tick();
            end
        end
        lit_state("t3_shl", 8'h08, 1'b0, 1'b0, 1'b0);

        issue(OP_LDI, 8'h81);
        issue(OP_SHR, 8'h03);
        tick();
        chk("t3_shr_busy_s2", 1, 32'(d_rdy[1]), 32'd0);
        tick();
        chk("t3_shr_ov_s2", 1, 32'(d_ov[1]), 32'd1);
        chk("t3_shr_acc_s2", 1, 32'(d_acc[1]), 32'h10);
        wait_idle();
        lit_state("t3_shr", 8'h10, 1'b0, 1'b0, 1'b0);
        issue(OP_SHL, 8'h08);
        chk("t3_shl8_rdy", 0, {30'd0, d_rdy}, 32'd3);
        chk("t3_shl8_ov", 1, {30'd0, d_ov}, 32'd3);
        lit_state("t3_shl8", 8'h00, 1'b0, 1'b1, 1'b0);
        issue(OP_LDI, 8'hC3);
        issue(OP_SHR, 8'h07);
        wait_idle();
        lit_state("t3_shr7", 8'h01, 1'b0, 1'b0, 1'b1);

        // Mixed table, model-checked.
        t_ops  = '{OP_LDI, OP_AND, OP_XOR, OP_NOT, OP_LDR, OP_MLD, OP_SUB, OP_SUB,
                   OP_STR, OP_MST, OP_SHR, OP_SHL, OP_LDI, OP_SHL, OP_SHR, OP_BRN};
        t_vals = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h80, 8'h01, 8'h01, 8'h01,
                   8'h00, 8'h00, 8'h00, 8'h09, 8'h97, 8'h07, 8'h06, 8'h00};
        for (int i = 0; i < 16; i++) issue(t_ops[i], t_vals[i]);
        chk("tbl_brn", 0, 32'(d_br[0]), 32'd0);
        lit_state("tbl_end", 8'h02, 1'b0, 1'b0, 1'b0);

        // New instruction presented throughout a shift is ignored.
        issue(OP_LDI, 8'h81);
        wait_idle();
        in_valid = 1'b1; op = OP_SHL; operand = 8'h03;
        tick();
        op = OP_LDI; operand = 8'hAA;
        tick();
        tick();
        in_valid = 1'b0;
        wait_idle();
        lit_state("t5", 8'h08, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a shift.
        issue(OP_LDI, 8'hFF);
        issue(OP_ADD, 8'h01);
        issue(OP_LDI, 8'h81);
        lit_state("t6_pre", 8'h81, 1'b1, 1'b0, 1'b1);
        issue(OP_SHL, 8'h05);
        tick();
        chk("t6_mid_acc_s1", 0, 32'(d_acc[0]), 32'h02);
        #2;
        reset_n = 1'b0;
        #1;
        lit_state("t6_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_rdy", 0, {30'd0, d_rdy}, 32'd3);
        chk("t6_rst_ov", 1, {30'd0, d_ov}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        chk("t6_no_ov", 0, {30'd0, d_ov}, 32'd0);
        issue(OP_LDI, 8'h3C);
        issue(OP_XOR, 8'hFF);
        lit_state("t6_after", 8'hC3, 1'b1, 1'b0, 1'b0);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
